if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage directly downstream of the program counter. Takes the current PC, issues single-outstanding read requests to instruction memory over a req/ack handshake, and buffers returned instructions with their PCs in a small FIFO for the decode stage (valid/ready). Supplies a hold signal back to the PC register and discards in-flight or buffered fetches on a branch flush.

## Interface
Parameters:
- DEPTH, 2, FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- pc  in  32  current fetch address from PC register.
- ce  in  1  PC valid / fetch enable from PC register.
- flush  in  1  branch taken this cycle (same signal that loads the branch target into the PC).
- pc_hold  out  1  PC register must not advance this cycle; `flush` has priority over `pc_hold` in the PC register.
- imem_req  out  1  read request, registered.
- imem_addr  out  32  read address, registered; stable while `imem_req` = 1.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  32  instruction word, sampled when `imem_ack` = 1.
- id_valid  out  1  head FIFO entry valid.
- id_inst  out  32  head instruction.
- id_pc  out  32  PC of head instruction.
- id_ready  in  1  decode consumes head when `id_valid` & `id_ready`.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, result wanted.
  - DROP: request outstanding, result to be discarded.
- `accept = (state == IDLE) & ce & ~flush & (count < DEPTH)`. `count` is the current-cycle value; a same-cycle pop is not credited.
- `pc_hold = ~accept`, combinational.
- IDLE:
  - If `accept`: `imem_addr <= pc`, `imem_req <= 1`, go to WAIT.
  - Otherwise stay in IDLE with `imem_req` = 0.
- WAIT:
  - `imem_ack` & ~`flush`: push {`imem_addr`, `imem_rdata`}, `imem_req <= 0`, go to IDLE.
  - `imem_ack` & `flush`: discard the data, `imem_req <= 0`, go to IDLE.
  - ~`imem_ack` & `flush`: go to DROP, keep `imem_req` = 1.
- DROP: keep `imem_req` = 1 until `imem_ack`, discard the data, go to IDLE. A `flush` arriving in DROP has no further effect.
- Handshake rule: once `imem_req` rises, it and `imem_addr` stay constant until the `imem_ack` cycle. They are never withdrawn by a flush.
- FIFO:
  - Circular buffer with `wr_ptr`, `rd_ptr` (log2(DEPTH) bits, wrap naturally) and `count` (0..DEPTH).
  - `id_valid = (count != 0)`. `id_inst`/`id_pc` = entry at `rd_ptr`.
  - Push and pop in the same cycle: both pointers advance, `count` unchanged.
  - Pop when `count` = 0 is ignored. Push never occurs when full (guaranteed by `accept`).
- `flush` clears the FIFO on the same edge: pointers and `count` go to 0. It overrides push and pop.

## Timing
- Reset (`rst` = 0, asynchronous):
  - state IDLE, `imem_req` = 0, `imem_addr` = 0.
  - pointers and `count` = 0, storage = 0.
  - Hence `id_valid` = 0, `id_inst` = 0, `id_pc` = 0 immediately.
  - `pc_hold` follows its equation.
- Reset mid-WAIT/DROP: request drops at once. Memory must tolerate an abandoned request.
- Request issue: `imem_req` rises on the edge after the `accept` cycle.
- Data path: `imem_ack` at edge N pushes; `id_valid` = 1 after edge N.
- Minimum ack latency: 0 cycles, i.e. ack in the first cycle `imem_req` is high.
- Fetch → decode latency: 2 cycles with zero-wait memory.
- Peak throughput: one instruction per 2 cycles (IDLE is visited between requests).
- `pc_hold` is high whenever state ≠ IDLE, during reset, with `ce` = 0, or when the FIFO is full.

## Test plan
- Reset: assert `rst` = 0 while in WAIT with 1 entry buffered → `imem_req`, `id_valid`, `id_pc` all 0 before the next edge; after release, first request goes to `pc` = 0x0000_0000.
- Basic fetch: `ce` = 1, `pc` = 0x0000_0000, `id_ready` = 1, ack in first req cycle with `imem_rdata` = 0x2001_0005 → `id_valid` = 1, `id_inst` = 0x2001_0005, `id_pc` = 0x0; next `imem_addr` = 0x0000_0004.
- Backpressure, DEPTH = 2, `id_ready` = 0: fetch 0x0 and 0x4 → `count` = 2, `pc_hold` stays 1, no further `imem_req`. Raise `id_ready` for one cycle → head 0x0 popped, next request 0x8 issued.
- Flush in WAIT without ack (addr 0x8): `flush` = 1, `pc` → 0x40 → DROP. Ack with 0xDEAD_BEEF after 3 cycles → not pushed, `id_valid` = 0. Next `imem_addr` = 0x0000_0040.
- Flush, ack and pop in the same cycle with 1 entry buffered → `count` = 0, `id_valid` = 0, state IDLE, nothing pushed.
- Variable ack latency (0, 1, 3 cycles): `imem_addr` and `imem_req` constant until ack; `id_pc` sequence 0x0, 0x4, 0x8 in order.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch: issues one outstanding imem read per PC and queues {pc, inst} for decode.
// Latency: req on the edge after accept; data visible on id_* the edge after imem_ack.
// Backpressure: pc_hold stalls the PC while busy, full, disabled or in reset; id_ready pops the head.
//
// Ports:
//   clk_i, rst_ni                - clock, asynchronous active-low reset
//   pc_i, ce_i, flush_i          - PC register interface (address, valid, branch taken)
//   pc_hold_o                    - PC register must not advance this cycle
//   imem_req_o, imem_addr_o      - registered read request / address
//   imem_ack_i, imem_rdata_i     - read response
//   id_valid_o, id_inst_o,       - head of the fetch buffer toward decode
//   id_pc_o, id_ready_i
module if_fetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic        flush_i,
    output logic        pc_hold_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o,
    input  logic        id_ready_i
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [31:0]       addr_q, addr_d;

    logic [31:0]       inst_q [DEPTH];
    logic [31:0]       pcbuf_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              accept;
    logic              push;
    logic              pop;

    // A same-cycle pop does not free a slot for this cycle's accept; reset forces hold.
    assign accept    = rst_ni & (state_q == S_IDLE) & ce_i & ~flush_i & (count_q < FULL);
    assign pc_hold_o = ~accept;

    assign pop = id_ready_i & (count_q != '0);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        push    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = pc_i;
                    req_d   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack_i) begin
                    push    = ~flush_i;
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (flush_i) begin
                    // Request cannot be withdrawn; remember to discard its data.
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_ack_i) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    // Fetch buffer: flush empties it and overrides any push or pop on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i]  <= '0;
                pcbuf_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                inst_q[wr_ptr_q]  <= imem_rdata_i;
                pcbuf_q[wr_ptr_q] <= addr_q;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign id_valid_o  = (count_q != '0);
    assign id_inst_o   = inst_q[rd_ptr_q];
    assign id_pc_o     = pcbuf_q[rd_ptr_q];

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        ce;
    logic        flush;
    logic        pc_hold;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one outstanding fetch and a queue of {pc, inst}.
    bit          m_busy;
    bit          m_keep;
    logic [31:0] m_addr;
    logic [63:0] m_q[$];

    if_fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pc_i         (pc),
        .ce_i         (ce),
        .flush_i      (flush),
        .pc_hold_o    (pc_hold),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_ack_i   (imem_ack),
        .imem_rdata_i (imem_rdata),
        .id_valid_o   (id_valid),
        .id_inst_o    (id_inst),
        .id_pc_o      (id_pc),
        .id_ready_i   (id_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_keep = 0;
        m_addr = 32'h0;
        m_q.delete();
    endtask

    function automatic bit model_accept();
        return !m_busy && ce && !flush && (m_q.size() < DEPTH);
    endfunction

    task automatic model_check();
        chk("pc_hold", {31'b0, pc_hold}, {31'b0, !model_accept()});
        chk("imem_req", {31'b0, imem_req}, {31'b0, m_busy});
        chk("imem_addr", imem_addr, m_addr);
        chk("id_valid", {31'b0, id_valid}, {31'b0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            chk("id_pc", id_pc, m_q[0][63:32]);
            chk("id_inst", id_inst, m_q[0][31:0]);
        end
    endtask

    task automatic model_edge();
        bit acc;
        acc = model_accept();
        if (flush) begin
            m_q.delete();
        end else begin
            if (id_ready && m_q.size() != 0) void'(m_q.pop_front());
            if (m_busy && m_keep && imem_ack) m_q.push_back({m_addr, imem_rdata});
        end
        if (m_busy && imem_ack) begin
            m_busy = 0;
        end else if (acc) begin
            m_busy = 1;
            m_keep = 1;
            m_addr = pc;
        end else if (m_busy && flush) begin
            m_keep = 0;
        end
    endtask

    // One cycle: drive at edge+1, check at edge+2, advance model, then edge.
    task automatic cyc(input bit c, input logic [31:0] p, input bit fl, input bit ack,
                       input logic [31:0] rd, input bit rdy);
        ce         = c;
        pc         = p;
        flush      = fl;
        imem_ack   = ack && m_busy;
        imem_rdata = rd;
        id_ready   = rdy;
        #1;
        model_check();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pc_reg;
        int lat[3];
        rst_n = 1'b0; pc = 0; ce = 0; flush = 0; imem_ack = 0; imem_rdata = 0; id_ready = 0;
        model_reset();
        #3;
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_inst", id_inst, 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_hold", {31'b0, pc_hold}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic fetch
        cyc(1, 32'h0, 0, 0, 0, 1);
        chk("basic_req", {31'b0, imem_req}, 32'h1);
        cyc(1, 32'h0, 0, 1, 32'h2001_0005, 1);
        chk("basic_valid", {31'b0, id_valid}, 32'h1);
        chk("basic_inst", id_inst, 32'h2001_0005);
        chk("basic_pc", id_pc, 32'h0);
        cyc(1, 32'h4, 0, 0, 0, 1);
        chk("basic_next_addr", imem_addr, 32'h4);

        // Backpressure: fill both entries
        cyc(1, 32'h4, 0, 1, 32'h1111_0004, 0);
        cyc(1, 32'h8, 0, 0, 0, 0);
        cyc(1, 32'hC, 0, 1, 32'h1111_0008, 0);
        cyc(1, 32'hC, 0, 0, 0, 0);
        chk("full_req", {31'b0, imem_req}, 32'h0);
        cyc(1, 32'hC, 0, 0, 0, 1);
        chk("after_pop_head", id_pc, 32'h8);
        cyc(1, 32'hC, 0, 0, 0, 0);
        chk("after_pop_addr", imem_addr, 32'hC);

        // Flush in WAIT without ack, late ack discarded
        cyc(1, 32'h40, 1, 0, 0, 0);
        cyc(1, 32'h40, 0, 0, 0, 0);
        cyc(1, 32'h40, 1, 0, 0, 0);
        cyc(1, 32'h40, 0, 1, 32'hDEAD_BEEF, 0);
        chk("drop_valid", {31'b0, id_valid}, 32'h0);
        cyc(1, 32'h40, 0, 0, 0, 0);
        chk("drop_next_addr", imem_addr, 32'h40);

        // Flush + ack + pop in one cycle with one entry buffered
        cyc(1, 32'h44, 0, 1, 32'h1111_0040, 0);
        cyc(1, 32'h44, 0, 0, 0, 0);
        cyc(1, 32'h80, 1, 1, 32'h1111_0044, 1);
        chk("ffp_valid", {31'b0, id_valid}, 32'h0);
        chk("ffp_req", {31'b0, imem_req}, 32'h0);

        // Variable ack latency 0, 1, 3
        lat[0] = 0; lat[1] = 1; lat[2] = 3;
        for (int k = 0; k < 3; k++) begin
            cyc(1, 32'(4 * k), 0, 0, 0, 1);
            for (int w = 0; w < lat[k]; w++) cyc(1, 32'(4 * k + 4), 0, 0, 0, 1);
            cyc(1, 32'(4 * k + 4), 0, 1, 32'hA000_0000 + 32'(k), 0);
            chk("lat_id_pc", id_pc, 32'(4 * k));
        end

        // Reset mid-WAIT with one buffered entry
        cyc(1, 32'h100, 0, 0, 0, 1);
        cyc(1, 32'h100, 0, 1, 32'h1234_5678, 0);
        cyc(1, 32'h104, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, imem_req}, 32'h0);
        chk("mid_rst_valid", {31'b0, id_valid}, 32'h0);
        chk("mid_rst_pc", id_pc, 32'h0);
        chk("mid_rst_hold", {31'b0, pc_hold}, 32'h1);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1, 32'h0, 0, 0, 0, 0);
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("post_rst_req", {31'b0, imem_req}, 32'h1);

        // Randomized traffic with a PC register emulation
        pc_reg = 32'h4;
        for (int i = 0; i < 600; i++) begin
            bit fl;
            bit c;
            bit acc;
            fl = ($urandom_range(0, 9) == 0);
            c  = ($urandom_range(0, 3) != 0);
            ce = c; pc = pc_reg; flush = fl;
            acc = model_accept();
            cyc(c, pc_reg, fl, $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1);
            if (fl) pc_reg = {$urandom_range(0, 16'hFFFF), 2'b00};
            else if (acc) pc_reg = pc_reg + 32'h4;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
